spart_fifo: RTL and testbench

Parametrised successor to the single-byte SPART: a processor-mapped UART with configurable character width, TX/RX FIFOs, parity, a 1/2 stop-bit option, sticky error flags and internal loopback. It sits on the same 8-bit iocs/iorw/ioaddr processor bus and drives/receives the board serial pins. A 16x-oversampling baud generator is built in, loaded from a divisor register.

---
 rtl/spart_fifo.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spart_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spart_fifo.sv
// spart_fifo: processor-mapped UART with TX/RX FIFOs, parity, 1/2 stop bits,
// sticky error flags, internal loopback and a 16x oversampling baud generator.
module spart_fifo_buf #(
  parameter int W = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(D));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle pops.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_reg] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (clr) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + AW'(1);
      if (do_pop)  rptr_reg <= rptr_reg + AW'(1);
      if (do_push && !do_pop) count_reg <= count_reg + (AW+1)'(1);
      if (!do_push && do_pop) count_reg <= count_reg - (AW+1)'(1);
    end
  end
endmodule

module spart_fifo #(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_DIV  = 16'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rxd,
  output logic       txd,
  output logic       rda,
  output logic       tbr,
  output logic       irq
);
  localparam logic [15:0] RESET_CNT = (RESET_DIV == 16'd0) ? 16'd0 : RESET_DIV - 16'd1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

  typedef struct packed {
    tx_state_t            state;
    logic [3:0]           tcnt;
    logic [2:0]           bits;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en;
    logic                 par_bit;
    logic                 two_stop;
    logic                 stop2;
  } tx_t;

  typedef struct packed {
    rx_state_t            state;
    logic [3:0]           tcnt;
    logic [2:0]           bits;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en;
    logic                 odd;
    logic                 par_bad;
  } rx_t;

  tx_t         tx_reg, tx_next;
  rx_t         rx_reg, rx_next;
  logic [5:0]  ctrl_reg;
  logic [15:0] div_reg, div_next, baud_cnt_reg;
  logic        sync1_reg, sync2_reg;
  logic        overrun_reg, frame_err_reg, parity_err_reg;

  logic wr, rd, flush, stat_rd, div_wr, tick;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_start, tx_bit_end, tx_avail, tx_serial, tx_idle;
  logic rx_push, rx_pop, rx_full, rx_empty, rx_in, rx_sample, set_frame, set_par, set_overrun;
  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic [7:0] rdata;

  assign wr      = iocs && !iorw;
  assign rd      = iocs && iorw;
  assign flush   = wr && (ioaddr == 2'b01) && databus[7];
  assign stat_rd = rd && (ioaddr == 2'b01);
  assign div_wr  = wr && ioaddr[1];
  assign tx_push = wr && (ioaddr == 2'b00);
  assign rx_pop  = rd && (ioaddr == 2'b00);

  spart_fifo_buf #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_tx_buf (
    .clk(clk), .rst(rst), .clr(flush), .push(tx_push), .pop(tx_pop),
    .wdata(databus[DATA_BITS-1:0]), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  spart_fifo_buf #(.W(DATA_BITS), .D(FIFO_DEPTH)) u_rx_buf (
    .clk(clk), .rst(rst), .clr(flush), .push(rx_push), .pop(rx_pop),
    .wdata(rx_reg.shift), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    div_next = div_reg;
    if (wr && ioaddr == 2'b10) div_next[7:0]  = databus;
    if (wr && ioaddr == 2'b11) div_next[15:8] = databus;
  end

  // Divisor 0 parks the counter at 0 with tick gated off, freezing both FSMs.
  assign tick = (div_reg != 16'd0) && (baud_cnt_reg == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg        <= RESET_DIV;
      baud_cnt_reg   <= RESET_CNT;
      ctrl_reg       <= '0;
      sync1_reg      <= 1'b1;
      sync2_reg      <= 1'b1;
      overrun_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      tx_reg         <= '0;
      rx_reg         <= '0;
    end else begin
      div_reg <= div_next;
      if (div_wr)     baud_cnt_reg <= (div_next == 16'd0) ? 16'd0 : div_next - 16'd1;
      else if (tick)  baud_cnt_reg <= div_reg - 16'd1;
      else if (baud_cnt_reg != 16'd0) baud_cnt_reg <= baud_cnt_reg - 16'd1;
      if (wr && ioaddr == 2'b01) ctrl_reg <= databus[5:0];
      sync1_reg      <= rxd;
      sync2_reg      <= sync1_reg;
      overrun_reg    <= set_overrun || (overrun_reg && !stat_rd);
      frame_err_reg  <= set_frame || (frame_err_reg && !stat_rd);
      parity_err_reg <= set_par || (parity_err_reg && !stat_rd);
      tx_reg         <= tx_next;
      rx_reg         <= rx_next;
    end
  end

  assign tx_bit_end = tick && (tx_reg.tcnt == 4'hF);
  assign tx_avail   = !tx_empty && !flush;

  always_comb begin
    tx_next  = tx_reg;
    tx_pop   = 1'b0;
    tx_start = 1'b0;
    if (tick && tx_reg.state != TX_IDLE) tx_next.tcnt = tx_reg.tcnt + 4'd1;
    case (tx_reg.state)
      TX_IDLE:  tx_start = tick && tx_avail;
      TX_START: if (tx_bit_end) begin
        tx_next.state = TX_DATA;
        tx_next.bits  = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_next.shift = tx_reg.shift >> 1;
        tx_next.bits  = tx_reg.bits + 3'd1;
        tx_next.stop2 = 1'b0;
        if (tx_reg.bits == 3'(DATA_BITS-1)) tx_next.state = tx_reg.par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: if (tx_bit_end) tx_next.state = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_reg.two_stop && !tx_reg.stop2) tx_next.stop2 = 1'b1;
        else if (tx_avail)                    tx_start = 1'b1;
        else                                  tx_next.state = TX_IDLE;
      end
      default: tx_next.state = TX_IDLE;
    endcase
    // Frame settings are captured here so control writes only affect the next character.
    if (tx_start) begin
      tx_pop           = 1'b1;
      tx_next.state    = TX_START;
      tx_next.tcnt     = '0;
      tx_next.shift    = tx_head;
      tx_next.par_en   = ctrl_reg[0] ^ ctrl_reg[1];
      tx_next.par_bit  = (^tx_head) ^ ctrl_reg[1];
      tx_next.two_stop = ctrl_reg[2];
    end
  end

  always_comb begin
    case (tx_reg.state)
      TX_START:  tx_serial = 1'b0;
      TX_DATA:   tx_serial = tx_reg.shift[0];
      TX_PARITY: tx_serial = tx_reg.par_bit;
      default:   tx_serial = 1'b1;
    endcase
  end

  assign rx_in     = ctrl_reg[3] ? tx_serial : sync2_reg;
  assign rx_sample = tick && (rx_reg.tcnt == ((rx_reg.state == RX_START) ? 4'd7 : 4'd15));

  always_comb begin
    rx_next   = rx_reg;
    rx_push   = 1'b0;
    set_frame = 1'b0;
    set_par   = 1'b0;
    if (tick && rx_reg.state != RX_IDLE) rx_next.tcnt = rx_reg.tcnt + 4'd1;
    case (rx_reg.state)
      RX_IDLE: if (tick && !rx_in) begin
        rx_next.state   = RX_START;
        rx_next.tcnt    = '0;
        rx_next.par_en  = ctrl_reg[0] ^ ctrl_reg[1];
        rx_next.odd     = ctrl_reg[1];
        rx_next.par_bad = 1'b0;
      end
      RX_START: if (rx_sample) begin
        rx_next.tcnt  = '0;
        rx_next.bits  = '0;
        rx_next.state = rx_in ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_next.shift = {rx_in, rx_reg.shift[DATA_BITS-1:1]};
        rx_next.bits  = rx_reg.bits + 3'd1;
        if (rx_reg.bits == 3'(DATA_BITS-1)) rx_next.state = rx_reg.par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_sample) begin
        rx_next.par_bad = ((^rx_reg.shift) ^ rx_reg.odd) != rx_in;
        rx_next.state   = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        if (!rx_in) begin
          set_frame     = 1'b1;
          rx_next.state = RX_WAIT;
        end else begin
          rx_push       = 1'b1;
          set_par       = rx_reg.par_bad;
          rx_next.state = RX_IDLE;
        end
      end
      RX_WAIT: if (tick && rx_in) rx_next.state = RX_IDLE;
      default: rx_next.state = RX_IDLE;
    endcase
    if (flush) begin
      rx_next.state = RX_IDLE;
      rx_push       = 1'b0;
    end
  end

  assign set_overrun = rx_push && rx_full && !rx_pop;
  assign tx_idle     = (tx_reg.state == TX_IDLE) && tx_empty;
  assign rda         = !rx_empty;
  assign tbr         = !tx_full;
  assign irq         = (rda && ctrl_reg[4]) || (tx_idle && ctrl_reg[5]);
  assign txd         = ctrl_reg[3] ? 1'b1 : tx_serial;

  always_comb begin
    rdata = 8'h00;
    case (ioaddr)
      2'b00:   if (!rx_empty) rdata = 8'(rx_head);
      2'b01:   rdata = {2'b00, parity_err_reg, frame_err_reg, overrun_reg, tx_idle, tbr, rda};
      2'b10:   rdata = div_reg[7:0];
      default: rdata = div_reg[15:8];
    endcase
  end

  assign databus = rd ? rdata : 8'bz;
endmodule

// File: tb/tb_spart_fifo.sv
// Directed self-checking bench for spart_fifo: TX timing, loopback, FIFO limits,
// receive errors, asynchronous reset and glitch rejection.
module tb_spart_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] drive = 8'h00;
  logic       drive_en = 1'b0;
  logic       rxd = 1'b1;
  logic       txd, rda, tbr, irq;
  wire  [7:0] databus;
  int         n_checks = 0;
  int         n_errors = 0;

  assign databus = drive_en ? drive : 8'bz;
  always #5 clk = ~clk;

  spart_fifo dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rxd(rxd), .txd(txd), .rda(rda), .tbr(tbr), .irq(irq)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drive = d; drive_en = 1'b1;
    @(posedge clk);
    #1;
    iocs = 1'b0; iorw = 1'b1; drive_en = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1;
    iocs = 1'b0;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  task automatic send_frame(input logic [7:0] d, input int par, input logic stop);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (64) @(negedge clk);
    end
    if (par >= 0) begin
      rxd = par[0];
      repeat (64) @(negedge clk);
    end
    rxd = stop;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    $display("rx frame data=%h parity=%0d stop=%0d", d, par, stop);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rv;
    logic [7:0] pat;
    logic       found;
    logic       txd_low;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_txd", txd, 1'b1);
    check_val("reset_rda", rda, 1'b0);
    check_val("reset_tbr", tbr, 1'b1);
    check_val("reset_irq", irq, 1'b0);
    bus_read(2'b01, rv); check_val("reset_status", rv, 8'h06);
    bus_read(2'b10, rv); check_val("reset_div_lo", rv, 8'h00);

    // Plain TX of 0x55 at divisor 4: 64 clocks per bit, 640 per frame
    bus_write(2'b10, 8'h04);
    bus_read(2'b10, rv); check_val("div_lo_readback", rv, 8'h04);
    bus_write(2'b00, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd == 1'b0) begin found = 1'b1; break; end
    end
    check_val("t1_start_seen", found, 1'b1);
    repeat (63) @(negedge clk);
    check_val("t1_start_end", txd, 1'b0);
    pat = 8'h55;
    @(negedge clk);
    check_val("t1_bit0", txd, pat[0]);
    for (int k = 1; k < 8; k++) begin
      repeat (64) @(negedge clk);
      check_val($sformatf("t1_bit%0d", k), txd, pat[k]);
    end
    repeat (64) @(negedge clk);
    check_val("t1_stop", txd, 1'b1);
    repeat (62) @(negedge clk);
    bus_read(2'b01, rv); check_val("t1_busy_at_639", rv, 8'h02);
    bus_read(2'b01, rv); check_val("t1_idle_at_640", rv, 8'h06);

    // Loopback with RX interrupt enable
    bus_write(2'b01, 8'h18);
    bus_write(2'b00, 8'hA5);
    bus_write(2'b00, 8'h3C);
    txd_low = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txd == 1'b0) txd_low = 1'b1;
      if (rda) begin found = 1'b1; break; end
    end
    check_val("t2_rda_frame1", found, 1'b1);
    check_val("t2_irq", irq, 1'b1);
    bus_read(2'b00, rv); check_val("t2_char1", rv, 8'hA5);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txd == 1'b0) txd_low = 1'b1;
      if (rda) begin found = 1'b1; break; end
    end
    check_val("t2_rda_frame2", found, 1'b1);
    bus_read(2'b00, rv); check_val("t2_char2", rv, 8'h3C);
    check_val("t2_rda_empty", rda, 1'b0);
    bus_read(2'b00, rv); check_val("t2_empty_read", rv, 8'h00);
    check_val("t2_txd_held_high", txd_low, 1'b0);

    // Fill TX at divisor 0, then release at divisor 2; loopback counts output
    bus_write(2'b01, 8'h88);
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    for (int i = 0; i < 9; i++) begin
      bus_write(2'b00, 8'h10 + 8'(i));
      if (i >= 6) check_val($sformatf("t3_tbr_after_%0d", i + 1), tbr, (i == 6) ? 1'b1 : 1'b0);
    end
    bus_read(2'b01, rv); check_val("t3_status_full", rv, 8'h00);
    bus_write(2'b10, 8'h02);
    repeat (3500) @(negedge clk);
    bus_read(2'b01, rv); check_val("t3_status_done", rv, 8'h07);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'b00, rv); check_val($sformatf("t3_char%0d", i), rv, 8'h10 + 8'(i));
    end
    bus_read(2'b01, rv); check_val("t3_exactly8", rv, 8'h06);

    // RX overrun: nine characters into an eight-deep RX FIFO
    for (int i = 0; i < 8; i++) bus_write(2'b00, 8'h20 + 8'(i));
    repeat (60) @(negedge clk);
    bus_write(2'b00, 8'h28);
    repeat (3500) @(negedge clk);
    bus_read(2'b01, rv); check_val("t4_overrun_set", rv, 8'h0F);
    bus_read(2'b01, rv); check_val("t4_overrun_clear", rv, 8'h07);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'b00, rv); check_val($sformatf("t4_char%0d", i), rv, 8'h20 + 8'(i));
    end
    check_val("t4_rda_empty", rda, 1'b0);

    // External rxd: frame error, then even parity error on 0x07
    bus_write(2'b01, 8'h00);
    bus_write(2'b10, 8'h04);
    repeat (20) @(negedge clk);
    send_frame(8'h5A, -1, 1'b0);
    repeat (200) @(negedge clk);
    bus_read(2'b01, rv); check_val("t5_frame_err", rv, 8'h16);
    bus_read(2'b01, rv); check_val("t5_frame_clear", rv, 8'h06);
    bus_write(2'b01, 8'h01);
    send_frame(8'h07, 0, 1'b1);
    repeat (100) @(negedge clk);
    bus_read(2'b01, rv); check_val("t5_parity_err", rv, 8'h27);
    bus_read(2'b00, rv); check_val("t5_parity_char", rv, 8'h07);
    bus_read(2'b01, rv); check_val("t5_after", rv, 8'h06);

    // Asynchronous reset in the middle of a transmission
    bus_write(2'b01, 8'h00);
    bus_write(2'b00, 8'h00);
    bus_write(2'b00, 8'h00);
    bus_write(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    check_val("t6_txd_low_pre", txd, 1'b0);
    @(negedge clk);
    rst = 1'b1; iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
    #2;
    check_val("t6_rst_txd", txd, 1'b1);
    check_val("t6_rst_status", databus, 8'h06);
    check_val("t6_rst_tbr", tbr, 1'b1);
    check_val("t6_rst_irq", irq, 1'b0);
    repeat (3) @(negedge clk);
    iocs = 1'b0; rst = 1'b0;
    bus_read(2'b10, rv); check_val("t6_div_reset", rv, 8'h00);

    // One-tick low glitch on rxd is rejected
    bus_write(2'b10, 8'h04);
    repeat (10) @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    check_val("t6_glitch_rda", rda, 1'b0);
    bus_read(2'b01, rv); check_val("t6_glitch_status", rv, 8'h06);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
